// File: rtl/uart_cmd_ctrl.sv
// Frames SYNC/OPC/DHI/DLO/CHK commands from a UART receiver, checks the
// modulo-256 checksum and inter-byte timeout, and holds accepted commands for a valid/ack consumer.
module uart_cmd_ctrl #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 104160,
    parameter int         TO_W        = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rdy,
    output logic [7:0]  cmd_opc,
    output logic [15:0] cmd_data,
    output logic        cmd_vld,
    input  logic        cmd_ack,
    output logic        err,
    output logic [1:0]  err_code
);
    typedef enum logic [2:0] {S_HUNT, S_OPC, S_DHI, S_DLO, S_CHK} state_t;

    // Timeout fires on the cycle the counter would step to TIMEOUT_CYC-1.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 2);

    state_t          r_state, w_state_nxt;
    logic [TO_W-1:0] r_to;
    logic [7:0]      r_sum, r_fopc, r_fdhi, r_fdlo;
    logic            r_clr_rdy, r_cmd_vld, r_err;
    logic [7:0]      r_cmd_opc;
    logic [15:0]     r_cmd_data;
    logic [1:0]      r_err_code, w_err_code_nxt;
    logic            w_acc, w_to_hit, w_err_set, w_commit;

    // clr_rdy masks acceptance so a still-high rdy is not consumed twice.
    assign w_acc    = rx_rdy & ~r_clr_rdy;
    assign w_to_hit = (r_state != S_HUNT) && !w_acc && (r_to == TO_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_err_set      = 1'b0;
        w_err_code_nxt = r_err_code;
        w_commit       = 1'b0;
        if (w_to_hit) begin
            w_state_nxt    = S_HUNT;
            w_err_set      = 1'b1;
            w_err_code_nxt = 2'b10;
        end else if (w_acc) begin
            case (r_state)
                S_HUNT: if (rx_data == SYNC_BYTE) w_state_nxt = S_OPC;
                S_OPC:  w_state_nxt = S_DHI;
                S_DHI:  w_state_nxt = S_DLO;
                S_DLO:  w_state_nxt = S_CHK;
                S_CHK: begin
                    w_state_nxt = S_HUNT;
                    if (rx_data != r_sum) begin
                        w_err_set      = 1'b1;
                        w_err_code_nxt = 2'b01;
                    end else if (!r_cmd_vld || cmd_ack) begin
                        w_commit = 1'b1;
                    end else begin
                        w_err_set      = 1'b1;
                        w_err_code_nxt = 2'b11;
                    end
                end
                default: w_state_nxt = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_HUNT;
            r_to       <= '0;
            r_clr_rdy  <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_rdy  <= w_acc;
            r_err      <= w_err_set;
            r_err_code <= w_err_code_nxt;
            if (r_state == S_HUNT || w_acc || w_to_hit)
                r_to <= '0;
            else
                r_to <= r_to + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= 8'h00;
            r_fopc <= 8'h00;
            r_fdhi <= 8'h00;
            r_fdlo <= 8'h00;
        end else if (w_acc && !w_to_hit) begin
            case (r_state)
                S_HUNT: if (rx_data == SYNC_BYTE) r_sum <= 8'h00;
                S_OPC: begin
                    r_fopc <= rx_data;
                    r_sum  <= rx_data;
                end
                S_DHI: begin
                    r_fdhi <= rx_data;
                    r_sum  <= r_sum + rx_data;
                end
                S_DLO: begin
                    r_fdlo <= rx_data;
                    r_sum  <= r_sum + rx_data;
                end
                default: ;
            endcase
        end
    end

    // A commit wins over a coincident ack, so vld stays high with new data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_vld  <= 1'b0;
            r_cmd_opc  <= 8'h00;
            r_cmd_data <= 16'h0000;
        end else if (w_commit) begin
            r_cmd_vld  <= 1'b1;
            r_cmd_opc  <= r_fopc;
            r_cmd_data <= {r_fdhi, r_fdlo};
        end else if (cmd_ack && r_cmd_vld) begin
            r_cmd_vld  <= 1'b0;
        end
    end

    assign clr_rdy  = r_clr_rdy;
    assign cmd_opc  = r_cmd_opc;
    assign cmd_data = r_cmd_data;
    assign cmd_vld  = r_cmd_vld;
    assign err      = r_err;
    assign err_code = r_err_code;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: vector table, hand-written timeout/reset
// sequences, and randomized frames checked against a byte-level frame model.
module tb_uart_cmd_ctrl;
    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rdy;
    logic [7:0]  cmd_opc;
    logic [15:0] cmd_data;
    logic        cmd_vld;
    logic        cmd_ack;
    logic        err;
    logic [1:0]  err_code;

    uart_cmd_ctrl #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(T), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rdy(clr_rdy),
        .cmd_opc(cmd_opc), .cmd_data(cmd_data), .cmd_vld(cmd_vld), .cmd_ack(cmd_ack),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks = 0, passes = 0;
    int cyc = 0, err_cnt = 0, clr_cnt = 0, err_cyc = 0, last_clr_cyc = 0;
    logic [1:0] err_last = 2'b00;

    always @(posedge clk) begin
        if (err) begin
            err_cnt++;
            err_last = err_code;
            err_cyc  = cyc;
        end
        if (clr_rdy) clr_cnt++;
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Frame model: tracks hunting/collecting, checksum, holding register and errors per byte.
    bit         m_hunt = 1'b1;
    logic [7:0] m_fr [3];
    int         m_idx = 0, m_gap = 0, m_nerr = 0, m_nbytes = 0;
    logic [7:0] m_opc = 8'h00;
    logic [15:0] m_data = 16'h0000;
    bit         m_vld = 1'b0;
    logic [1:0] m_code = 2'b00;

    task automatic m_err(input logic [1:0] c);
        m_nerr++;
        m_code = c;
    endtask

    task automatic m_byte(input logic [7:0] b, input bit ack);
        bit committed = 1'b0;
        m_nbytes++;
        m_gap = 0;
        if (m_hunt) begin
            if (b == 8'hA5) begin
                m_hunt = 1'b0;
                m_idx  = 0;
            end
        end else if (m_idx < 3) begin
            m_fr[m_idx] = b;
            m_idx++;
        end else begin
            m_hunt = 1'b1;
            if (int'(b) != (int'(m_fr[0]) + int'(m_fr[1]) + int'(m_fr[2])) % 256) m_err(2'b01);
            else if (!m_vld || ack) begin
                m_opc = m_fr[0];
                m_data = {m_fr[1], m_fr[2]};
                m_vld = 1'b1;
                committed = 1'b1;
            end else m_err(2'b11);
        end
        if (ack && !committed) m_vld = 1'b0;
    endtask

    // Idle cycles since the last accepted byte; an interval of T cycles or more times out.
    task automatic m_idle(input int n);
        m_gap += n;
        if (!m_hunt && 2 + m_gap >= T) begin
            m_hunt = 1'b1;
            m_err(2'b10);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        m_idle(n);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ack, input int gap);
        @(negedge clk);
        rx_data = b; rx_rdy = 1'b1; cmd_ack = ack;
        chk("clr_before_accept", clr_rdy, 1'b0);
        @(negedge clk);
        cmd_ack = 1'b0;
        chk("clr_pulse", clr_rdy, 1'b1);
        last_clr_cyc = cyc;
        rx_rdy = 1'b0;
        m_byte(b, ack);
        idle(gap);
    endtask

    task automatic pulse_ack();
        @(negedge clk); cmd_ack = 1'b1;
        @(negedge clk); cmd_ack = 1'b0;
        m_vld = 1'b0;
        m_idle(2);
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_opc"}, cmd_opc, m_opc);
        chk({tag, "_data"}, cmd_data, m_data);
        chk({tag, "_vld"}, cmd_vld, m_vld);
        chk({tag, "_nerr"}, err_cnt, m_nerr);
        chk({tag, "_code"}, err_last, m_code);
        chk({tag, "_nclr"}, clr_cnt, m_nbytes);
    endtask

    task automatic send_frame(input logic [7:0] o, input logic [15:0] d, input logic [7:0] ck);
        send_byte(8'hA5, 1'b0, 0);
        send_byte(o, 1'b0, 0);
        send_byte(d[15:8], 1'b0, 0);
        send_byte(d[7:0], 1'b0, 0);
        send_byte(ck, 1'b0, 0);
    endtask

    typedef struct {
        int         n;
        logic [7:0] b [7];
        bit         pre_ack;
        bit         ack_last;
        logic [7:0] opc;
        logic [15:0] data;
        bit         vld;
        int         nerr;
        logic [1:0] code;
    } vec_t;

    vec_t v [6];

    function automatic int rgap();
        return ($urandom % 8 == 0) ? (T - 3 + int'($urandom % 2)) : int'($urandom % 4);
    endfunction

    initial begin
        int e0, c0;
        v[0] = '{5, '{8'hA5, 8'h47, 8'h12, 8'h34, 8'h8D, 8'h00, 8'h00}, 1'b0, 1'b0, 8'h47, 16'h1234, 1'b1, 0, 2'b00};
        v[1] = '{7, '{8'h00, 8'hFF, 8'hA5, 8'h53, 8'h00, 8'h10, 8'h63}, 1'b1, 1'b0, 8'h53, 16'h0010, 1'b1, 0, 2'b00};
        v[2] = '{5, '{8'hA5, 8'h47, 8'h12, 8'h34, 8'h8E, 8'h00, 8'h00}, 1'b1, 1'b0, 8'h53, 16'h0010, 1'b0, 1, 2'b01};
        v[3] = '{5, '{8'hA5, 8'h47, 8'h12, 8'h34, 8'h8D, 8'h00, 8'h00}, 1'b1, 1'b0, 8'h47, 16'h1234, 1'b1, 0, 2'b00};
        v[4] = '{5, '{8'hA5, 8'h53, 8'h00, 8'h10, 8'h63, 8'h00, 8'h00}, 1'b0, 1'b0, 8'h47, 16'h1234, 1'b1, 1, 2'b11};
        v[5] = '{5, '{8'hA5, 8'h53, 8'h00, 8'h10, 8'h63, 8'h00, 8'h00}, 1'b0, 1'b1, 8'h53, 16'h0010, 1'b1, 0, 2'b00};

        rst = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0; cmd_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_clr", clr_rdy, 1'b0);
        chk("rst_vld", cmd_vld, 1'b0);
        chk("rst_opc", cmd_opc, 8'h00);
        chk("rst_data", cmd_data, 16'h0000);
        chk("rst_err", {err, err_code}, 3'b000);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            if (v[i].pre_ack) pulse_ack();
            e0 = err_cnt; c0 = clr_cnt;
            for (int j = 0; j < v[i].n; j++)
                send_byte(v[i].b[j], v[i].ack_last && (j == v[i].n - 1), 0);
            idle(2);
            chk($sformatf("vec%0d_opc", i), cmd_opc, v[i].opc);
            chk($sformatf("vec%0d_data", i), cmd_data, v[i].data);
            chk($sformatf("vec%0d_vld", i), cmd_vld, v[i].vld);
            chk($sformatf("vec%0d_nerr", i), err_cnt - e0, v[i].nerr);
            chk($sformatf("vec%0d_nclr", i), clr_cnt - c0, v[i].n);
            if (v[i].nerr > 0) chk($sformatf("vec%0d_code", i), err_last, v[i].code);
        end

        // Timeout after A5 47 12: err rises T-1 cycles after the 0x12 clr_rdy pulse.
        pulse_ack();
        e0 = err_cnt;
        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h47, 1'b0, 0);
        send_byte(8'h12, 1'b0, 0);
        c0 = last_clr_cyc;
        idle(T + 3);
        chk("to_nerr", err_cnt - e0, 1);
        chk("to_code", err_last, 2'b10);
        chk("to_latency", err_cyc - c0, T - 1);
        chk("to_vld", cmd_vld, 1'b0);
        send_frame(8'h10, 16'h0001, 8'h11);
        idle(2);
        chk("after_to_opc", cmd_opc, 8'h10);
        chk("after_to_data", cmd_data, 16'h0001);
        chk("after_to_nerr", err_cnt - e0, 1);

        // Longest legal gap is accepted; one cycle longer times out.
        pulse_ack();
        e0 = err_cnt;
        send_byte(8'hA5, 1'b0, T - 3);
        send_byte(8'h47, 1'b0, 0);
        send_byte(8'h12, 1'b0, 0);
        send_byte(8'h34, 1'b0, 0);
        send_byte(8'h8D, 1'b0, 0);
        idle(2);
        chk("maxgap_nerr", err_cnt - e0, 0);
        chk("maxgap_vld", cmd_vld, 1'b1);
        send_byte(8'hA5, 1'b0, T - 2);
        idle(2);
        chk("overgap_nerr", err_cnt - e0, 1);
        chk("overgap_code", err_last, 2'b10);
        cmp_model("hand");

        for (int k = 0; k < 60; k++) begin
            int mode = int'($urandom % 5);
            if (mode <= 2) begin
                logic [7:0] o, dh, dl, ck;
                o = 8'($urandom); dh = 8'($urandom); dl = 8'($urandom);
                ck = 8'((int'(o) + int'(dh) + int'(dl)) % 256);
                if (mode == 2) ck = ck ^ (8'h01 << ($urandom % 8));
                send_byte(8'hA5, $urandom % 4 == 0, rgap());
                send_byte(o, $urandom % 4 == 0, rgap());
                send_byte(dh, $urandom % 4 == 0, rgap());
                send_byte(dl, $urandom % 4 == 0, rgap());
                send_byte(ck, $urandom % 3 == 0, rgap());
            end else if (mode == 3) begin
                send_byte(8'($urandom), $urandom % 4 == 0, rgap());
            end else begin
                send_byte(8'hA5, 1'b0, 0);
                for (int j = 0; j < int'($urandom % 3); j++) send_byte(8'($urandom), 1'b0, 0);
            end
            idle(2);
            cmp_model($sformatf("rnd%0d", k));
        end

        // Reset mid-frame discards A5 47; the next frame is framed from scratch.
        pulse_ack();
        send_frame(8'h47, 16'h1234, 8'h8D);
        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h47, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", cmd_vld, 1'b0);
        chk("mid_rst_opc", cmd_opc, 8'h00);
        chk("mid_rst_data", cmd_data, 16'h0000);
        chk("mid_rst_err", {clr_rdy, err, err_code}, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        e0 = err_cnt;
        send_frame(8'h47, 16'h1234, 8'h8D);
        idle(2);
        chk("post_rst_opc", cmd_opc, 8'h47);
        chk("post_rst_data", cmd_data, 16'h1234);
        chk("post_rst_vld", cmd_vld, 1'b1);
        chk("post_rst_nerr", err_cnt - e0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
